cfg_chain_loader: RTL and testbench

- Upstream feeder for the PE configuration scan chain.
- Accepts configuration words over a valid/ready stream and serialises them, LSB first, onto the chain's serial config input, one bit per enabled cycle.
- Pulses the chain's config reset before loading, counts exactly CHAIN_LEN shifted bits, then reports completion.
- Sits between the host/config DMA and the first config_in of a PE column (e.g. a block of 4-bit ALU, 1-bit MEM and switch config cells).

---
 rtl/cfg_chain_loader.sv | 69 ++++++
 tb/tb_cfg_chain_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serialises config words LSB first onto a PE config scan chain after a chain clear.
module cfg_chain_loader #(
  parameter int WORD_W     = 32,
  parameter int CHAIN_LEN  = 64,
  parameter int CNT_W      = 16,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_out,
  output logic              cfg_shift,
  output logic              cfg_reset_o,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_sent
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, FIN} state_t;
  state_t             state_q;
  logic [WORD_W-1:0]  shreg_q;
  logic [CNT_W-1:0]   bits_q, wbit_q, clr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bits_q  <= '0;
      wbit_q  <= '0;
      clr_q   <= '0;
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= CLEAR;
          bits_q  <= '0;
          clr_q   <= '0;
        end
        CLEAR: if (clr_q == CNT_W'(CLR_CYCLES - 1)) state_q <= LOAD;
               else clr_q <= clr_q + 1'b1;
        LOAD: if (in_valid) begin
          shreg_q <= in_data;
          wbit_q  <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          shreg_q <= shreg_q >> 1;
          wbit_q  <= wbit_q + 1'b1;
          bits_q  <= bits_q + 1'b1;
          // chain end wins over word end, dropping any unused tail of the last word
          state_q <= (bits_q == CNT_W'(CHAIN_LEN - 1)) ? FIN :
                     (wbit_q == CNT_W'(WORD_W - 1))    ? LOAD : SHIFT;
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready    = (state_q == LOAD) && !abort && !reset;
  assign cfg_shift   = state_q == SHIFT;
  assign cfg_out     = (state_q == SHIFT) && shreg_q[0];
  assign cfg_reset_o = state_q == CLEAR;
  assign busy        = state_q != IDLE;
  assign done        = state_q == FIN;
  assign bits_sent   = bits_q;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: randomized checks of cfg_chain_loader against a bit-stream and cycle-count model.
module tb_cfg_chain_loader;
  localparam int W = 32;
  localparam int CLR = 2;
  logic clk = 0, reset = 1, start64 = 0, start40 = 0, abort = 0, in_valid = 0;
  logic [W-1:0] in_data = '0;
  logic r64, c64, s64, x64, b64, d64, r40, c40, s40, x40, b40, d40;
  logic [15:0] n64, n40;
  cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(64), .CNT_W(16), .CLR_CYCLES(CLR)) u64 (
    .clk(clk), .reset(reset), .start(start64), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(r64), .cfg_out(c64), .cfg_shift(s64), .cfg_reset_o(x64), .busy(b64), .done(d64), .bits_sent(n64));
  cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(40), .CNT_W(16), .CLR_CYCLES(CLR)) u40 (
    .clk(clk), .reset(reset), .start(start40), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(r40), .cfg_out(c40), .cfg_shift(s40), .cfg_reset_o(x40), .busy(b40), .done(d40), .bits_sent(n40));
  always #5 clk = ~clk;
  int sel = 0, cyc = 0, t0 = 0, total = 0, bad = 0;
  int done_cnt, done_at, first_at, clr_cnt;
  logic [15:0] bs0;
  logic [W-1:0] words[$];
  logic got[$];
  wire rdy = sel ? r40 : r64;
  wire cout = sel ? c40 : c64;
  wire shf = sel ? s40 : s64;
  wire crst = sel ? x40 : x64;
  wire bsy = sel ? b40 : b64;
  wire dn = sel ? d40 : d64;
  wire [15:0] bits = sel ? n40 : n64;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (shf) begin
      if (first_at < 0) first_at = cyc - t0;
      got.push_back(cout);
    end
    if (dn) begin
      done_cnt++;
      done_at = cyc - t0;
    end
    if (crst) clr_cnt++;
  end
  function automatic int exp_done(int L, int gap);
    int d = CLR + 1 + gap;
    for (int b = 0; b < L; b += W) d += 1 + ((L - b) < W ? L - b : W);
    return d;
  endfunction
  function automatic int stream_errs(int L);
    int e = (got.size() == L) ? 0 : 1;
    for (int i = 0; i < L && i < got.size(); i++) begin
      logic [W-1:0] w = words[i / W];
      if (got[i] !== w[i % W]) e++;
    end
    return e;
  endfunction
  task automatic run(input int s, input int gap, input int ab_n, input int st_n, input int rs_n);
    int wi = 0, gl = gap;
    bit hs, fin = 0, fired = 0;
    sel = s;
    @(posedge clk); #1;
    got.delete(); done_cnt = 0; done_at = -1; first_at = -1; clr_cnt = 0;
    t0 = cyc;
    if (s != 0) start40 = 1; else start64 = 1;
    in_valid = words.size() > 0;
    in_data = words[0];
    @(posedge clk); #1;
    start40 = 0; start64 = 0;
    bs0 = bits;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      hs = in_valid & rdy;
      if (rdy && !in_valid && wi == 1 && gl > 0) gl--;
      @(posedge clk); #1;
      abort = 0; reset = 0; start40 = 0; start64 = 0;
      if (hs) wi++;
      in_valid = wi < words.size() && !(wi == 1 && gl > 0);
      in_data = (wi < words.size()) ? words[wi] : W'($urandom);
      if (!bsy) fin = 1;
      else if (!fired && ab_n >= 0 && got.size() == ab_n) begin abort = 1; fired = 1; end
      else if (!fired && rs_n >= 0 && got.size() == rs_n) begin reset = 1; fired = 1; end
      else if (!fired && st_n >= 0 && got.size() == st_n) begin
        if (s != 0) start40 = 1; else start64 = 1;
        fired = 1;
      end
    end
    in_valid = 0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL run_timeout: busy still %0b, required 0 within 400 cycles", bsy);
    end
  endtask
  task automatic test_reset;
    reset = 1; in_valid = 1; start64 = 1; start40 = 1;
    repeat (3) @(posedge clk);
    #1; start64 = 0; start40 = 0;
    @(negedge clk);
    total++;
    if ({r64, c64, s64, x64, b64, d64, n64} !== '0) begin
      bad++; $display("FAIL reset64: got %b, required 0", {r64, c64, s64, x64, b64, d64, n64});
    end
    total++;
    if ({r40, c40, s40, x40, b40, d40, n40} !== '0) begin
      bad++; $display("FAIL reset40: got %b, required 0", {r40, c40, s40, x40, b40, d40, n40});
    end
    @(posedge clk); #1; reset = 0; in_valid = 0;
  endtask
  task automatic test_basic;
    int e;
    words = '{32'hA5A5_0001, 32'hFFFF_0000};
    run(0, 0, -1, -1, -1);
    e = stream_errs(64);
    total++;
    if (clr_cnt !== CLR) begin bad++; $display("FAIL basic_clear: got %0d cycles, required %0d", clr_cnt, CLR); end
    total++;
    if (first_at !== CLR + 2) begin bad++; $display("FAIL basic_latency: got %0d, required %0d", first_at, CLR + 2); end
    total++;
    if (e !== 0) begin bad++; $display("FAIL basic_stream: %0d errors over %0d bits, required 0 of 64", e, got.size()); end
    total++;
    if (done_cnt !== 1 || done_at !== 69) begin bad++; $display("FAIL basic_done: got %0d pulses at %0d, required 1 at 69", done_cnt, done_at); end
    total++;
    if (bits !== 16'd64) begin bad++; $display("FAIL basic_bits: got %0d, required 64", bits); end
  endtask
  task automatic test_partial;
    int e, ones = 0;
    words = '{32'hFFFF_FFFF, 32'h0000_00FF};
    run(1, 0, -1, -1, -1);
    e = stream_errs(40);
    for (int i = 32; i < 40 && i < got.size(); i++) ones += got[i];
    total++;
    if (e !== 0 || ones !== 8) begin bad++; $display("FAIL partial_stream: %0d errors, %0d tail ones, required 0 and 8", e, ones); end
    total++;
    if (done_cnt !== 1 || done_at !== exp_done(40, 0)) begin bad++; $display("FAIL partial_done: got %0d at %0d, required 1 at %0d", done_cnt, done_at, exp_done(40, 0)); end
    total++;
    if (bits !== 16'd40) begin bad++; $display("FAIL partial_bits: got %0d, required 40", bits); end
  endtask
  task automatic test_backpressure;
    int e;
    words = '{W'($urandom), W'($urandom)};
    run(0, 5, -1, -1, -1);
    e = stream_errs(64);
    total++;
    if (e !== 0) begin bad++; $display("FAIL bp_stream: %0d errors, required 0", e); end
    total++;
    if (done_at !== 74) begin bad++; $display("FAIL bp_done: got %0d, required 74", done_at); end
  endtask
  task automatic test_abort;
    words = '{W'($urandom), W'($urandom)};
    run(0, 0, 10, -1, -1);
    @(negedge clk);
    total++;
    if (bits !== 16'd10 || done_cnt !== 0) begin bad++; $display("FAIL abort_state: bits %0d done %0d, required 10 and 0", bits, done_cnt); end
    total++;
    if ({bsy, shf, crst, rdy} !== 4'b0) begin bad++; $display("FAIL abort_outputs: got %b, required 0000", {bsy, shf, crst, rdy}); end
    run(0, 0, -1, -1, -1);
    total++;
    if (bs0 !== 16'd0 || clr_cnt !== CLR) begin bad++; $display("FAIL abort_restart: bits %0d clear %0d, required 0 and %0d", bs0, clr_cnt, CLR); end
    total++;
    if (stream_errs(64) !== 0 || done_at !== 69) begin bad++; $display("FAIL abort_rerun: done at %0d, required 69 with clean stream", done_at); end
  endtask
  task automatic test_spurious_start;
    words = '{W'($urandom), W'($urandom)};
    run(0, 0, -1, 20, -1);
    total++;
    if (stream_errs(64) !== 0 || done_cnt !== 1 || done_at !== 69) begin
      bad++; $display("FAIL spurious_start: %0d bits, done %0d at %0d, required 64, 1 at 69", got.size(), done_cnt, done_at);
    end
  endtask
  task automatic test_reset_mid;
    int hi = 0;
    words = '{W'($urandom), W'($urandom)};
    run(0, 0, -1, -1, 15);
    @(negedge clk);
    total++;
    if ({rdy, cout, shf, crst, bsy, dn, bits} !== '0) begin bad++; $display("FAIL reset_mid: got %b, required 0", {rdy, cout, shf, crst, bsy, dn, bits}); end
    in_valid = 1;
    repeat (5) begin @(negedge clk); hi += rdy; end
    in_valid = 0;
    total++;
    if (hi !== 0) begin bad++; $display("FAIL reset_mid_ready: in_ready high %0d cycles, required 0", hi); end
  endtask
  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      int s = $urandom_range(0, 1), g = $urandom_range(0, 6), L;
      L = s ? 40 : 64;
      words = '{W'($urandom), W'($urandom), W'($urandom)};
      run(s, g, -1, -1, -1);
      total++;
      if (stream_errs(L) !== 0 || done_at !== exp_done(L, g) || bits !== 16'(L)) begin
        bad++; $display("FAIL random_%0d: len %0d done %0d bits %0d, required len %0d done %0d", k, got.size(), done_at, bits, L, exp_done(L, g));
      end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_partial;
    test_backpressure;
    test_abort;
    test_spurious_start;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
